pulse_scheduler: RTL and testbench
==================================

Name: pulse_scheduler

Overview:
Time-shares one programmable pulse-train generator among N_REQ requesters using round-robin arbitration. The granted requester receives a burst of burst_len single-cycle pulses, spaced `period` cycles apart. The burst ends with a one-cycle done strobe, then the block re-arbitrates. It sits above the simple fixed-period pulse generators and replaces per-consumer generators with one shared, configurable source.

Parameters:
N_REQ, 4, number of requesters (≥2)
PER_W, 4, width of period field
LEN_W, 8, width of burst-length field

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester request, level-sensitive
period  input  PER_W  cycles between pulses, sampled at grant; 0 treated as 1
burst_len  input  LEN_W  pulses per burst, sampled at grant
grant  output  N_REQ  one-hot owner of the generator, all-zero when idle
pulse  output  1  shared pulse output, registered
busy  output  1  high in RUN and DONE
done  output  1  one-cycle strobe at end of burst
aborted  output  1  valid with done; 1 if burst ended by owner dropping req

Behaviour:
- Reset (async, rst_n=0): grant=0, pulse=0, busy=0, done=0, aborted=0, state=IDLE, RR pointer=0, counters=0. Release is synchronous to clk.
- States:
  - IDLE → RUN when any req bit is high.
  - RUN → DONE after the last pulse, or on abort.
  - DONE → IDLE unconditionally.
- Arbitration (IDLE only):
  - Scan starts at the RR pointer index, wraps modulo N_REQ; the first set req wins.
  - Next cycle: grant[winner]=1, period and burst_len latched, phase counter=0, pulse counter=0.
  - RR pointer ← (winner+1) mod N_REQ.
- Timing: cycle 0 is the first cycle grant is high.
  - With P = max(period,1) and L = burst_len, pulse=1 exactly in cycles P-1, 2P-1, …, L·P-1.
  - Phase counter runs 0..P-1 and wraps.
  - Pulse counter increments on each pulse.
- End of burst: the cycle after the L-th pulse, state=DONE; grant holds, done=1, aborted=0. Following cycle: IDLE, grant=0, busy=0.
- Zero-length burst: L=0 → cycle 0 is DONE (grant high one cycle, done=1, no pulse).
- Abort: owner's req low in any RUN cycle → next cycle DONE with pulse=0, done=1, aborted=1. Pulse counts are not completed.
- Back-to-back arbitration: the earliest re-grant is 2 cycles after done (DONE→IDLE, IDLE arbitrates).
- Other inputs: req changes from non-owners during RUN/DONE are ignored. period/burst_len changes after grant have no effect.
- Reset mid-burst: immediate return to reset values, RR pointer to 0.
- Invariants: grant is always one-hot or zero. pulse and done are never high in the same cycle.

Decomposition:
- Package pulse_sched_pkg: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, plus the default widths.
- Sub-module rr_arbiter (combinational).
  - Inputs: req, pointer.
  - Outputs: one-hot winner, winner index, any_req.
- pulse_scheduler holds the FSM, the latched config, and the phase/pulse counters.

Test Plan:
1. Single burst: req=4'b0001, period=2, burst_len=3.
   - Required: grant=0001 cycles 0–6.
   - pulse high cycles 1,3,5.
   - done=1 at cycle 6 with aborted=0; grant=0 at cycle 7.
2. Round-robin fairness: req=4'b1111 held, period=1, burst_len=1.
   - Required: grants in order 0001, 0010, 0100, 1000, 0001.
   - Each grant lasts 2 cycles, with 1 idle cycle between grants.
3. Edge configs:
   - period=0, burst_len=2 → behaves as P=1, pulses in cycles 0 and 1, done in cycle 2.
   - burst_len=0 → done in cycle 0 with no pulse.
4. Abort: req=0100, period=4, burst_len=5; drop req[2] at cycle 6.
   - Required: pulse only at cycle 3.
   - Cycle 7: done=1, aborted=1; cycle 8: grant=0.
5. Async reset mid-burst: assert rst_n=0 between clock edges during RUN.
   - Required: all outputs 0 immediately.
   - After release with req=0011: grant goes to requester 0 (pointer reset).
6. Config stability: change period/burst_len and toggle non-owner req bits during RUN.
   - Required: pulse spacing and count match the values latched at grant, and grant stays constant.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// -----------------------------------------------------------------------------
// pulse_sched_pkg
// Shared definitions for the pulse scheduler: FSM state encoding and the
// default parameter values used by pulse_scheduler and rr_arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_PER_W = 4;
  localparam int DEF_LEN_W = 8;

endpackage : pulse_sched_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The scan starts at i_ptr and wraps modulo
// N; the first asserted request wins.
//
// Ports:
//   i_req      [N-1:0]      request vector
//   i_ptr      [IDX_W-1:0]  scan start index (always < N)
//   o_win_oh   [N-1:0]      one-hot winner, zero when no request
//   o_win_idx  [IDX_W-1:0]  index of winner, zero when no request
//   o_any                   at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int N     = DEF_N_REQ,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_win_oh,
  output logic [IDX_W-1:0] o_win_idx,
  output logic             o_any
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N);

  always_comb begin
    logic [IDX_W:0] v_sum;
    logic           v_found;
    o_win_oh  = '0;
    o_win_idx = '0;
    v_found   = 1'b0;
    v_sum     = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit so ptr+i can exceed N-1 before the wrap subtraction.
      v_sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (v_sum >= N_L) begin
        v_sum = v_sum - N_L;
      end
      if (!v_found && i_req[v_sum[IDX_W-1:0]]) begin
        v_found                      = 1'b1;
        o_win_idx                    = v_sum[IDX_W-1:0];
        o_win_oh[v_sum[IDX_W-1:0]]   = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule : rr_arbiter

// File: rtl/pulse_scheduler.sv
// -----------------------------------------------------------------------------
// pulse_scheduler
// One programmable pulse-train generator time-shared between N_REQ
// requesters with round-robin arbitration. The owner gets burst_len
// single-cycle pulses spaced max(period,1) cycles apart, then a one-cycle
// done strobe, after which the block returns to IDLE and re-arbitrates.
//
// Handshake: req is a level. A requester holds req high until it sees done
// with its grant bit set; dropping req while granted in RUN aborts the burst
// (done with aborted=1 on the next cycle). grant is one-hot or zero.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   req       [N_REQ]   level requests
//   period    [PER_W]   pulse spacing, sampled at grant, 0 means 1
//   burst_len [LEN_W]   pulses per burst, sampled at grant
//   grant     [N_REQ]   current owner, zero when idle
//   pulse               registered pulse output
//   busy                high in RUN and DONE
//   done                one-cycle end-of-burst strobe
//   aborted             qualifies done: burst cut short by owner
//   dbg_state [2]       FSM state for observation
// -----------------------------------------------------------------------------
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PER_W = DEF_PER_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [PER_W-1:0] period,
  input  logic [LEN_W-1:0] burst_len,
  output logic [N_REQ-1:0] grant,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [1:0]       dbg_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           r_state,   w_state_nxt;
  logic [N_REQ-1:0] r_grant,   w_grant_nxt;
  logic [IDX_W-1:0] r_ptr,     w_ptr_nxt;
  logic [PER_W-1:0] r_per_m1,  w_per_m1_nxt;
  logic [PER_W-1:0] r_phase,   w_phase_nxt;
  logic [LEN_W-1:0] r_len,     w_len_nxt;
  logic [LEN_W-1:0] r_cnt,     w_cnt_nxt;
  logic             r_pulse,   w_pulse_nxt;
  logic             r_aborted, w_aborted_nxt;

  logic [N_REQ-1:0] w_win_oh;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_any;
  logic [PER_W-1:0] w_in_per_m1;
  logic [PER_W-1:0] w_phase_inc;
  logic [IDX_W-1:0] w_ptr_inc;
  logic             w_owner_req;
  logic             w_last_pulse;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req     (req),
    .i_ptr     (r_ptr),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx),
    .o_any     (w_any)
  );

  // The period is stored as P-1 so the phase compare needs no subtraction
  // and period=0 naturally collapses onto P=1.
  assign w_in_per_m1  = (period == '0) ? '0 : period - PER_W'(1);
  assign w_phase_inc  = (r_phase == r_per_m1) ? '0 : r_phase + PER_W'(1);
  assign w_ptr_inc    = (w_win_idx == IDX_W'(N_REQ - 1)) ? '0
                                                         : w_win_idx + IDX_W'(1);
  assign w_owner_req  = |(req & r_grant);
  // r_cnt counts pulses already emitted before this cycle.
  assign w_last_pulse = r_pulse && ((r_cnt + LEN_W'(1)) == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_per_m1  <= '0;
      r_phase   <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr     <= w_ptr_nxt;
      r_per_m1  <= w_per_m1_nxt;
      r_phase   <= w_phase_nxt;
      r_len     <= w_len_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pulse   <= w_pulse_nxt;
      r_aborted <= w_aborted_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    w_per_m1_nxt  = r_per_m1;
    w_phase_nxt   = r_phase;
    w_len_nxt     = r_len;
    w_cnt_nxt     = r_cnt;
    w_pulse_nxt   = 1'b0;
    w_aborted_nxt = r_aborted;

    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant_nxt   = w_win_oh;
          w_ptr_nxt     = w_ptr_inc;
          w_per_m1_nxt  = w_in_per_m1;
          w_len_nxt     = burst_len;
          w_phase_nxt   = '0;
          w_cnt_nxt     = '0;
          w_aborted_nxt = 1'b0;
          if (burst_len == '0) begin
            // Empty burst: the first granted cycle is already DONE.
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
            // Pulse is registered, so cycle 0 fires here when P=1.
            w_pulse_nxt = (w_in_per_m1 == '0);
          end
        end
      end

      ST_RUN: begin
        w_cnt_nxt = r_cnt + LEN_W'(r_pulse);
        if (!w_owner_req) begin
          w_state_nxt   = ST_DONE;
          w_aborted_nxt = 1'b1;
        end else if (w_last_pulse) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_phase_nxt = w_phase_inc;
          w_pulse_nxt = (w_phase_inc == r_per_m1);
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_phase_nxt = '0;
        w_cnt_nxt   = '0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  assign grant     = r_grant;
  assign pulse     = r_pulse;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign aborted   = (r_state == ST_DONE) && r_aborted;
  assign dbg_state = r_state;

endmodule : pulse_scheduler

// File: tb/tb_pulse_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pulse_scheduler
// Directed bench for pulse_scheduler. Each stimulus step drives the inputs for
// one cycle and pushes the expected outputs for that cycle; a monitor pops and
// compares on the falling edge.
// Expected vector layout: {grant[3:0], pulse, busy, done, aborted, state[1:0]}.
// -----------------------------------------------------------------------------
module tb_pulse_scheduler;

  localparam int W = 10;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] period;
  logic [7:0] burst_len;
  logic [3:0] grant;
  logic       pulse;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  pulse_scheduler #(.N_REQ(4), .PER_W(4), .LEN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .period    (period),
    .burst_len (burst_len),
    .grant     (grant),
    .pulse     (pulse),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic logic [W-1:0] mk(input logic [3:0] g, input logic pu,
                                      input logic d, input logic a);
    logic [1:0] st;
    st = (g == 4'b0000) ? 2'd0 : (d ? 2'd2 : 2'd1);
    return {g, pu, (g != 4'b0000), d, a, st};
  endfunction

  function automatic logic [W-1:0] act_vec();
    return {grant, pulse, busy, done, aborted, dbg_state};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (act_vec() !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t act=%b exp=%b (grant,pulse,busy,done,aborted,state)",
                 $time, act_vec(), e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1: drive this cycle's inputs and expected outputs.
  task automatic step(input logic [3:0] r, input logic [3:0] p, input logic [7:0] l,
                      input logic [3:0] g, input logic pu, input logic d, input logic a);
    req       = r;
    period    = p;
    burst_len = l;
    exp_q.push_back(mk(g, pu, d, a));
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (act_vec() !== '0) begin
      n_fail++;
      $display("FAIL %s act=%b exp=%b", name, act_vec(), {W{1'b0}});
    end
  endtask

  task automatic do_reset();
    req       = '0;
    period    = '0;
    burst_len = '0;
    rst_n     = 1'b0;
    #2;
    check_zero("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog timeout t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req       = '0;
    period    = '0;
    burst_len = '0;
    repeat (2) @(posedge clk);
    #1;

    // Test 2 first from reset: round-robin with all requesting, P=1, L=1.
    do_reset();
    step(4'b1111, 1, 1, 4'b0000, 0, 0, 0);
    for (int n = 0; n < 5; n++) begin
      logic [3:0] g;
      g = 4'b0001 << (n % 4);
      step(4'b1111, 1, 1, g, 1, 0, 0);
      step((n == 4) ? 4'b0000 : 4'b1111, 1, 1, g, 0, 1, 0);
      step((n == 4) ? 4'b0000 : 4'b1111, 1, 1, 4'b0000, 0, 0, 0);
    end

    // Test 1: single burst req=0001, P=2, L=3.
    do_reset();
    step(4'b0001, 2, 3, 4'b0000, 0, 0, 0);
    for (int c = 0; c <= 6; c++) begin
      step((c == 6) ? 4'b0000 : 4'b0001, 2, 3, 4'b0001,
           (c == 1 || c == 3 || c == 5), (c == 6), 0);
    end
    step(4'b0000, 2, 3, 4'b0000, 0, 0, 0);

    // Test 3a: period=0 behaves as P=1, L=2.
    do_reset();
    step(4'b1000, 0, 2, 4'b0000, 0, 0, 0);
    step(4'b1000, 0, 2, 4'b1000, 1, 0, 0);
    step(4'b1000, 0, 2, 4'b1000, 1, 0, 0);
    step(4'b0000, 0, 2, 4'b1000, 0, 1, 0);
    step(4'b0000, 0, 2, 4'b0000, 0, 0, 0);

    // Test 3b: zero-length burst.
    step(4'b0010, 3, 0, 4'b0000, 0, 0, 0);
    step(4'b0000, 3, 0, 4'b0010, 0, 1, 0);
    step(4'b0000, 3, 0, 4'b0000, 0, 0, 0);

    // Test 4: abort by owner at cycle 6, P=4, L=5.
    do_reset();
    step(4'b0100, 4, 5, 4'b0000, 0, 0, 0);
    for (int c = 0; c <= 7; c++) begin
      step((c >= 6) ? 4'b0000 : 4'b0100, 4, 5, 4'b0100,
           (c == 3), (c == 7), (c == 7));
    end
    step(4'b0000, 4, 5, 4'b0000, 0, 0, 0);

    // Test 5: async reset mid-burst restores the pointer to 0.
    do_reset();
    step(4'b0001, 1, 1, 4'b0000, 0, 0, 0);
    step(4'b0001, 1, 1, 4'b0001, 1, 0, 0);
    step(4'b0000, 1, 1, 4'b0001, 0, 1, 0);
    step(4'b0000, 1, 1, 4'b0000, 0, 0, 0);
    // Pointer is now 1; start another burst for requester 0.
    step(4'b0001, 2, 3, 4'b0000, 0, 0, 0);
    step(4'b0001, 2, 3, 4'b0001, 0, 0, 0);
    step(4'b0001, 2, 3, 4'b0001, 1, 0, 0);
    // In cycle 2 of the burst: reset between edges.
    #2;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_before_reset act=%b exp=1", busy);
    end
    rst_n = 1'b0;
    #1;
    check_zero("async_reset_mid_burst");
    req = 4'b0011;
    period = 1;
    burst_len = 1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(4'b0011, 1, 1, 4'b0001, 1, 0, 0);
    step(4'b0000, 1, 1, 4'b0001, 0, 1, 0);
    step(4'b0000, 1, 1, 4'b0000, 0, 0, 0);

    // Test 6: config and non-owner changes after grant are ignored. P=3, L=2.
    do_reset();
    step(4'b0010, 3, 2, 4'b0000, 0, 0, 0);
    for (int c = 0; c <= 6; c++) begin
      logic [3:0] r;
      r = (c == 6) ? 4'b0000 : (4'b0010 | 4'($urandom_range(0, 15)));
      step(r, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 4'b0010,
           (c == 2 || c == 5), (c == 6), 0);
    end
    step(4'b0000, 3, 2, 4'b0000, 0, 0, 0);

    // Drain scoreboard with a bounded wait.
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pulse_scheduler
